// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction and hands it downstream.
// Latency: 1 + N cycles from REQ entry to instr_valid (N = cycles imem_ready stays low); minimum period 2 cycles.
// Backpressure: waits in REQ until imem_ready; holds instr/pc in HOLD until instr_ack.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/ready/rdata instruction memory read handshake
//   instr_valid, instr, OP,   latched instruction and its decode fields
//   Funct, pc, pc_plus4       for the control unit
//   instr_ack, Jump, Branch,  downstream consume strobe with the next-PC
//   Zero                      decision inputs, sampled together
module instr_fetch_unit #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [5:0]       OP,
  output logic [5:0]       Funct,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  input  logic             instr_ack,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_pc;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_branch_off;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_capture;
  logic             w_advance;

  // Jump target keeps the top four bits of pc+4, so WIDTH must be at least 29.
  assign w_pc_plus4   = r_pc + WIDTH'(4);
  assign w_branch_off = {{(WIDTH-18){r_instr[15]}}, r_instr[15:0], 2'b00};

  // An x on Jump/Branch/Zero falls through the if/else chain to the next
  // lower-priority choice, so it behaves as 0.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (Jump == 1'b1) begin
      w_next_pc = {w_pc_plus4[WIDTH-1:28], r_instr[25:0], 2'b00};
    end else if ((Branch & Zero) == 1'b1) begin
      w_next_pc = w_pc_plus4 + w_branch_off;
    end
  end

  assign w_capture = (r_state == REQ)  && imem_ready;
  assign w_advance = (r_state == HOLD) && instr_ack;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = REQ;
      REQ:     if (imem_ready) w_next_state = HOLD;
      HOLD:    if (instr_ack)  w_next_state = REQ;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) r_instr <= imem_rdata;
      if (w_advance) r_pc    <= w_next_pc;
    end
  end

  // Handshake outputs decode the state register only; no input reaches them.
  assign imem_req    = (r_state == REQ);
  assign instr_valid = (r_state == HOLD);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign OP          = r_instr[31:26];
  assign Funct       = r_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  OP;
  logic [5:0]  Funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        Jump;
  logic        Branch;
  logic        Zero;

  instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .OP         (OP),
    .Funct      (Funct),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_ack  (instr_ack),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
  } exp_t;

  logic [31:0] q_addr[$];
  exp_t        q_ins[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a new request pops the expected fetch address, a new valid
  // instruction pops the expected pc/instr/decode fields.
  logic prev_req = 1'b0;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (imem_req === 1'b1 && prev_req !== 1'b1) begin
      if (q_addr.size() == 0) chk("unexpected_req", imem_addr, 32'hxxxx_xxxx);
      else chk("req_addr", imem_addr, q_addr.pop_front());
    end
    if (instr_valid === 1'b1 && prev_vld !== 1'b1) begin
      if (q_ins.size() == 0) begin
        chk("unexpected_valid", instr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q_ins.pop_front();
        chk("out_pc", pc, e.pc);
        chk("out_pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("out_instr", instr, e.instr);
        chk("out_op", {26'd0, OP}, {26'd0, e.op});
        chk("out_funct", {26'd0, Funct}, {26'd0, e.funct});
      end
    end
    prev_req = imem_req;
    prev_vld = instr_valid;
  end

  // One fetch: serve the request after `waits` wait states, stall the ack
  // for `stalls` cycles, then ack with the given J/B/Z and check the new pc.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] rdata,
                          input logic [5:0] op, input logic [5:0] funct,
                          input int waits, input int stalls,
                          input logic j, input logic b, input logic z,
                          input logic [31:0] exp_next);
    exp_t e;
    for (int k = 0; k < 8 && imem_req !== 1'b1; k++) @(negedge clk);
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    for (int k = 0; k < waits; k++) begin
      imem_ready = 1'b0;
      instr_ack  = 1'b1;            // ignored while requesting
      @(negedge clk);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    instr_ack  = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = rdata;
    e.pc = exp_pc; e.instr = rdata; e.op = op; e.funct = funct;
    q_ins.push_back(e);
    @(negedge clk);
    chk("valid_after_ready", {31'd0, instr_valid}, 32'd1);
    imem_rdata = 32'hDEAD_BEEF;     // ready stays high but must be ignored in HOLD
    for (int k = 0; k < stalls; k++) begin
      @(negedge clk);
      chk("stall_instr", instr, rdata);
      chk("stall_pc", pc, exp_pc);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ready = 1'b0;
    instr_ack  = 1'b1;
    Jump = j; Branch = b; Zero = z;
    q_addr.push_back(exp_next);
    @(negedge clk);
    instr_ack = 1'b0;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    chk("next_pc", pc, exp_next);
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("req_after_ack", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    instr_ack = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opfunct", {20'd0, OP, Funct}, 32'd0);
    rst = 1'b0; imem_ready = 1'b0;
    q_addr.push_back(32'h0);

    //       pc            rdata         op     funct  w  s  J  B  Z  next
    do_fetch(32'h0000_0000, 32'h012A4020, 6'h00, 6'h20, 0, 0, 0, 0, 0, 32'h0000_0004);
    do_fetch(32'h0000_0004, 32'h8C820004, 6'h23, 6'h04, 3, 5, 0, 0, 0, 32'h0000_0008);
    do_fetch(32'h0000_0008, 32'h0000_0000, 6'h00, 6'h00, 1, 0, 0, 0, 0, 32'h0000_000C);
    do_fetch(32'h0000_000C, 32'h0000_0000, 6'h00, 6'h00, 0, 0, 0, 0, 0, 32'h0000_0010);
    do_fetch(32'h0000_0010, 32'h1000FFFF, 6'h04, 6'h3F, 0, 1, 0, 1, 1, 32'h0000_0010);
    do_fetch(32'h0000_0010, 32'h10000003, 6'h04, 6'h03, 0, 0, 0, 1, 1, 32'h0000_0020);
    do_fetch(32'h0000_0020, 32'h1000FFFF, 6'h04, 6'h3F, 0, 0, 0, 1, 0, 32'h0000_0024);
    do_fetch(32'h0000_0024, 32'h08000100, 6'h02, 6'h00, 2, 0, 1, 1, 1, 32'h0000_0400);
    do_fetch(32'h0000_0400, 32'h1000FEFE, 6'h04, 6'h3E, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h2108FFFF, 6'h08, 6'h3F, 0, 0, 0, 0, 0, 32'h0000_0000);
    do_fetch(32'h0000_0000, 32'h3C01ABCD, 6'h0F, 6'h0D, 0, 0, 0, 0, 0, 32'h0000_0004);

    // Reset while requesting address 4; a ready pulse right after is not captured.
    rst = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    q_addr.push_back(32'h0);
    @(negedge clk);
    imem_ready = 1'b0;
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_instr", instr, 32'h0);
    chk("restart_valid", {31'd0, instr_valid}, 32'd0);

    do_fetch(32'h0000_0000, 32'h012A4020, 6'h00, 6'h20, 1, 0, 0, 0, 0, 32'h0000_0004);

    @(negedge clk);
    @(negedge clk);
    chk("addr_q_drained", q_addr.size(), 32'd0);
    chk("ins_q_drained", q_ins.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
